// File: rtl/enc_bundler.sv
// enc_bundler: sums per-dimension popcounts of 10-wide bound HV beats over NUM_BEATS beats
// and emits one registered sparse HV. Define ENC_BUNDLER_THINNING_EN for thresholded bundling.
module enc_bundler #(
    parameter int HV_DIM    = 1024,
    parameter int NUM_BEATS = 44,
    parameter int THRESHOLD = 4,
    localparam int CNT_W    = $clog2(10 * NUM_BEATS + 1)
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [HV_DIM-1:0] shifted_hv [0:9],
    output logic              out_valid,
    input  logic              out_ready,
    output logic [HV_DIM-1:0] encoded_hv,
    output logic              busy
);
    localparam int BEAT_W = $clog2(NUM_BEATS + 1);

    typedef enum logic [1:0] {IDLE, ACCUM, THRESH, DONE} state_t;

    state_t            state_reg, state_next;
    logic [BEAT_W-1:0] beat_cnt_reg;
    logic              accept;
    logic              release_out;
    logic              last_beat;
    logic [HV_DIM-1:0] hit;

    assign accept      = in_valid & in_ready;
    assign release_out = out_valid & out_ready;
    // Holds in IDLE too, so NUM_BEATS == 1 goes straight to THRESH.
    assign last_beat   = (beat_cnt_reg == BEAT_W'(NUM_BEATS - 1));

    always_ff @(posedge clk) begin
        if (nrst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b1;
        case (state_reg)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) begin
                    state_next = last_beat ? THRESH : ACCUM;
                end
            end
            ACCUM: begin
                in_ready = 1'b1;
                if (in_valid && last_beat) begin
                    state_next = THRESH;
                end
            end
            THRESH: begin
                state_next = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (nrst || release_out) begin
            beat_cnt_reg <= '0;
        end else if (accept) begin
            beat_cnt_reg <= beat_cnt_reg + 1'b1;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < HV_DIM; gi++) begin : g_dim
            logic [3:0]       pop;
            logic [CNT_W-1:0] cnt_reg;

            always_comb begin
                pop = '0;
                for (int k = 0; k < 10; k++) begin
                    pop = pop + 4'(shifted_hv[k][gi]);
                end
            end

            // Width covers 10*NUM_BEATS exactly, so the sum never wraps.
            always_ff @(posedge clk) begin
                if (nrst || release_out) begin
                    cnt_reg <= '0;
                end else if (accept) begin
                    cnt_reg <= cnt_reg + CNT_W'(pop);
                end
            end

`ifdef ENC_BUNDLER_THINNING_EN
            assign hit[gi] = (cnt_reg >= CNT_W'(THRESHOLD));
`else
            assign hit[gi] = (cnt_reg != '0);
`endif
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (nrst) begin
            encoded_hv <= '0;
        end else if (state_reg == THRESH) begin
            encoded_hv <= hit;
        end
    end

endmodule

// File: tb/tb_enc_bundler.sv
// Bench for enc_bundler: directed and random beats checked against a per-dimension count model.
module tb_enc_bundler;
    localparam int HV_DIM    = 1024;
    localparam int NUM_BEATS = 44;
    localparam int THRESHOLD = 4;

    logic              clk = 1'b0;
    logic              nrst;
    logic              in_valid;
    logic              in_ready;
    logic [HV_DIM-1:0] shifted_hv [0:9];
    logic              out_valid;
    logic              out_ready;
    logic [HV_DIM-1:0] encoded_hv;
    logic              busy;

    int total = 0;
    int bad   = 0;
    int cnt_m [HV_DIM];
    int samples = 0;

    always #5 clk = ~clk;

    enc_bundler #(
        .HV_DIM   (HV_DIM),
        .NUM_BEATS(NUM_BEATS),
        .THRESHOLD(THRESHOLD)
    ) dut (
        .clk       (clk),
        .nrst      (nrst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .shifted_hv(shifted_hv),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .encoded_hv(encoded_hv),
        .busy      (busy)
    );

    task automatic chk(input string tag, input logic [HV_DIM-1:0] obs, input logic [HV_DIM-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_data();
        for (int k = 0; k < 10; k++) shifted_hv[k] = '0;
    endtask

    task automatic model_clear();
        for (int d = 0; d < HV_DIM; d++) cnt_m[d] = 0;
    endtask

    task automatic model_add();
        for (int d = 0; d < HV_DIM; d++)
            for (int k = 0; k < 10; k++)
                cnt_m[d] += int'(shifted_hv[k][d]);
    endtask

    function automatic logic [HV_DIM-1:0] model_hv();
        logic [HV_DIM-1:0] v;
        for (int d = 0; d < HV_DIM; d++) begin
`ifdef ENC_BUNDLER_THINNING_EN
            v[d] = (cnt_m[d] >= THRESHOLD);
`else
            v[d] = (cnt_m[d] != 0);
`endif
        end
        return v;
    endfunction

    // One accepted beat with the data currently on shifted_hv.
    task automatic do_beat(input string tag);
        in_valid = 1'b1;
        chk({tag, "_in_ready"}, in_ready, 1'b1);
        @(posedge clk);
        model_add();
        #1;
        in_valid = 1'b0;
    endtask

    task automatic random_sparse(input int bit3);
        for (int k = 0; k < 10; k++) begin
            shifted_hv[k] = '0;
            repeat (4) shifted_hv[k][$urandom_range(0, HV_DIM - 1)] = 1'b1;
        end
        if (bit3 != 0) shifted_hv[2][3] = 1'b1;
    endtask

    // Called one cycle after the last beat edge: THRESH cycle, then DONE, then handshake.
    task automatic finish_sample(input string tag);
        logic [HV_DIM-1:0] exp;
        exp = model_hv();
        chk({tag, "_thresh_valid"}, out_valid, 1'b0);
        chk({tag, "_thresh_ready"}, in_ready, 1'b0);
        tick();
        chk({tag, "_done_valid"}, out_valid, 1'b1);
        chk({tag, "_done_hv"}, encoded_hv, exp);
        chk({tag, "_done_busy"}, busy, 1'b1);
        out_ready = 1'b1;
        tick();
        samples++;
        $display("sample %0d (%s): encoded ones=%0d", samples, tag, $countones(exp));
        chk({tag, "_post_valid"}, out_valid, 1'b0);
        chk({tag, "_post_ready"}, in_ready, 1'b1);
        chk({tag, "_post_busy"}, busy, 1'b0);
        out_ready = 1'b0;
        model_clear();
    endtask

    initial begin
        #50ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [HV_DIM-1:0] held;
        logic [HV_DIM-1:0] expc;
        int                accepted;

        nrst      = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        clear_data();
        model_clear();

        // Reset and idle
        tick();
        tick();
        nrst = 1'b0;
        tick();
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_hv", encoded_hv, '0);

        // All-zero sample, back-to-back with out_ready held high
        out_ready = 1'b1;
        for (int b = 0; b < NUM_BEATS; b++) begin
            do_beat("zero");
            if (b == 0) chk("zero_busy_first", busy, 1'b1);
        end
        finish_sample("zero");

        // Random sample then stall in DONE for 5 cycles while in_valid pulses
        for (int b = 0; b < NUM_BEATS; b++) begin
            random_sparse(0);
            do_beat("stall");
        end
        clear_data();
        tick();
        held = model_hv();
        chk("stall_done_valid", out_valid, 1'b1);
        chk("stall_done_hv", encoded_hv, held);
        shifted_hv[4][100] = 1'b1;
        for (int c = 0; c < 5; c++) begin
            in_valid = ($urandom_range(0, 1) == 1);
            chk("stall_in_ready", in_ready, 1'b0);
            tick();
            chk("stall_valid", out_valid, 1'b1);
            chk("stall_hv", encoded_hv, held);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        samples++;
        $display("sample %0d (stall): encoded ones=%0d", samples, $countones(held));
        chk("stall_release_ready", in_ready, 1'b1);
        chk("stall_release_valid", out_valid, 1'b0);
        out_ready = 1'b0;
        model_clear();
        clear_data();

        // Sparse directed sample: bit 5 once, bit 7 in all ten vectors
        shifted_hv[0][5] = 1'b1;
        do_beat("sparse");
        clear_data();
        for (int k = 0; k < 10; k++) shifted_hv[k][7] = 1'b1;
        do_beat("sparse");
        clear_data();
        for (int b = 2; b < NUM_BEATS; b++) do_beat("sparse");
        expc = '0;
        expc[7] = 1'b1;
`ifndef ENC_BUNDLER_THINNING_EN
        expc[5] = 1'b1;
`endif
        chk("sparse_model_const", model_hv(), expc);
        finish_sample("sparse");

        // Three beats with bit 9, then reset (with a beat offered) mid-accumulation
        for (int k = 0; k < 10; k++) shifted_hv[k][9] = 1'b1;
        for (int b = 0; b < 3; b++) do_beat("midrst");
        in_valid = 1'b1;
        nrst     = 1'b1;
        tick();
        nrst     = 1'b0;
        in_valid = 1'b0;
        model_clear();
        clear_data();
        chk("midrst_valid", out_valid, 1'b0);
        chk("midrst_ready", in_ready, 1'b1);
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_hv", encoded_hv, '0);
        for (int b = 0; b < NUM_BEATS; b++) begin
            do_beat("midrst");
            if (b < NUM_BEATS - 1) chk("midrst_early_valid", out_valid, 1'b0);
        end
        finish_sample("midrst");

        // Random 50% in_valid duty, bit 3 of vector 2 on every beat
        accepted = 0;
        for (int c = 0; c < 2000 && accepted < NUM_BEATS; c++) begin
            random_sparse(1);
            in_valid = ($urandom_range(0, 1) == 1);
            chk("rand_in_ready", in_ready, 1'b1);
            @(posedge clk);
            if (in_valid) begin
                model_add();
                accepted++;
            end
            #1;
            in_valid = 1'b0;
            if (accepted < NUM_BEATS) chk("rand_early_valid", out_valid, 1'b0);
        end
        chk("rand_budget", 32'(accepted), 32'(NUM_BEATS));
        clear_data();
        expc = model_hv();
        chk("rand_model_bit3", expc[3], 1'b1);
        tick();
        chk("rand_hv_bit3", encoded_hv[3], 1'b1);
        chk("rand_valid", out_valid, 1'b1);
        chk("rand_hv", encoded_hv, expc);
        out_ready = 1'b1;
        tick();
        samples++;
        $display("sample %0d (rand): encoded ones=%0d", samples, $countones(expc));
        chk("rand_post_ready", in_ready, 1'b1);
        out_ready = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
